qr_grid_sampler: RTL and testbench

Parametrised module-grid sampler for the QR decode pipeline. It replaces the three fixed version-1 downsample passes with a single engine. Given the top-left finder centre and a fractional module pitch, it walks every module of a version-`VERSION` symbol and reads 1 or 3 taps per module from the binary frame BRAM. It majority-votes the taps into one bit and returns the full grid to the unmask stage.

---
 rtl/qr_grid_sampler.sv | 169 ++++++++++++++++
 tb/tb_qr_grid_sampler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/qr_grid_sampler.sv
// Module-grid sampler: walks every module of a QR symbol from the top-left finder centre,
// reads 1 or 3 taps per module from the binary frame BRAM and majority-votes them into one bit.
module qr_grid_sampler #(
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int VERSION      = 1,
   parameter int TAPS         = 1,
   parameter int READ_LATENCY = 1,
   localparam int QR_SIZE     = 17 + 4*VERSION
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           start_sample,
   input  logic [9:0]                     origin_x,
   input  logic [9:0]                     origin_y,
   input  logic [11:0]                    mod_size_q4,
   input  logic                           pixel_data,
   output logic [19:0]                    pixel_address,
   output logic [QR_SIZE*QR_SIZE-1:0]     qr_grid,
   output logic                           busy,
   output logic                           grid_valid,
   output logic                           bounds_error
);

   localparam int GRID_BITS = QR_SIZE*QR_SIZE;
   localparam int RC_W      = $clog2(QR_SIZE);
   localparam int IDX_W     = $clog2(GRID_BITS);
   localparam logic signed [17:0] WIDTH_S  = 18'(WIDTH);
   localparam logic signed [17:0] HEIGHT_S = 18'(HEIGHT);

   typedef enum logic [2:0] {IDLE, SETUP, ADDR, WAIT, VOTE, DONE} state_t;

   state_t state, state_next;

   logic [11:0]        mod_q4;
   logic signed [15:0] row_acc, col_acc, col_base;
   logic [RC_W-1:0]    r, c;
   logic [1:0]         tap_idx, wait_cnt, vote_cnt;

   logic [15:0]        mod3;
   logic signed [15:0] row_init, col_init;
   logic signed [17:0] quarter, tap_off;
   logic signed [17:0] tap_x_q4, tap_y_q4, tap_x_px, tap_y_px;
   logic               in_bounds;
   logic [19:0]        addr_next;
   logic [IDX_W-1:0]   bit_idx;
   logic               last_wait, last_tap, last_col, last_row, vote_bit;

   // Module (3,3) is the finder centre, so the walk starts three pitches up and left of it.
   assign mod3     = {4'b0000, mod_size_q4} + {3'b000, mod_size_q4, 1'b0};
   assign row_init = $signed({2'b00, origin_y, 4'b0000}) - $signed(mod3);
   assign col_init = $signed({2'b00, origin_x, 4'b0000}) - $signed(mod3);

   assign quarter = $signed({8'b0000_0000, mod_q4[11:2]});

   always_comb begin
      tap_off = '0;
      if (TAPS == 3) begin
         case (tap_idx)
            2'd0:    tap_off = -quarter;
            2'd2:    tap_off = quarter;
            default: tap_off = '0;
         endcase
      end
   end

   // Round half up in Q4, arithmetic shift keeps negative coordinates negative for the bounds test.
   assign tap_x_q4  = 18'(col_acc) + tap_off + 18'sd8;
   assign tap_y_q4  = 18'(row_acc) + 18'sd8;
   assign tap_x_px  = tap_x_q4 >>> 4;
   assign tap_y_px  = tap_y_q4 >>> 4;
   assign in_bounds = (tap_x_px >= 18'sd0) && (tap_x_px < WIDTH_S) &&
                      (tap_y_px >= 18'sd0) && (tap_y_px < HEIGHT_S);
   assign addr_next = 20'(tap_y_px) * 20'(WIDTH) + 20'(tap_x_px);

   assign bit_idx   = IDX_W'(r) * IDX_W'(QR_SIZE) + IDX_W'(c);
   assign last_wait = (wait_cnt == 2'(READ_LATENCY-1));
   assign last_tap  = (tap_idx == 2'(TAPS-1));
   assign last_col  = (c == RC_W'(QR_SIZE-1));
   assign last_row  = (r == RC_W'(QR_SIZE-1));
   assign vote_bit  = (TAPS == 3) ? (vote_cnt >= 2'd2) : vote_cnt[0];

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_sample) state_next = SETUP;
         SETUP:   state_next = ADDR;
         ADDR:    state_next = in_bounds ? WAIT : DONE;
         WAIT:    if (last_wait) state_next = last_tap ? VOTE : ADDR;
         VOTE:    state_next = (last_row && last_col) ? DONE : ADDR;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == SETUP) || (state == ADDR) || (state == WAIT) || (state == VOTE);
      grid_valid = (state == DONE);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pixel_address <= '0;
         qr_grid       <= '0;
         bounds_error  <= 1'b0;
         mod_q4        <= '0;
         row_acc       <= '0;
         col_acc       <= '0;
         col_base      <= '0;
         r             <= '0;
         c             <= '0;
         tap_idx       <= '0;
         wait_cnt      <= '0;
         vote_cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_sample) bounds_error <= 1'b0;
            end
            SETUP: begin
               mod_q4   <= mod_size_q4;
               row_acc  <= row_init;
               col_acc  <= col_init;
               col_base <= col_init;
               r        <= '0;
               c        <= '0;
               tap_idx  <= '0;
               wait_cnt <= '0;
               vote_cnt <= '0;
               qr_grid  <= '0;
            end
            ADDR: begin
               wait_cnt <= '0;
               if (in_bounds) pixel_address <= addr_next;
               else           bounds_error  <= 1'b1;
            end
            WAIT: begin
               if (last_wait) begin
                  vote_cnt <= vote_cnt + {1'b0, pixel_data};
                  wait_cnt <= '0;
                  tap_idx  <= last_tap ? 2'd0 : tap_idx + 2'd1;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            VOTE: begin
               qr_grid[bit_idx] <= vote_bit;
               vote_cnt         <= '0;
               if (last_col) begin
                  c       <= '0;
                  col_acc <= col_base;
                  r       <= r + RC_W'(1);
                  row_acc <= row_acc + $signed({4'b0000, mod_q4});
               end else begin
                  c       <= c + RC_W'(1);
                  col_acc <= col_acc + $signed({4'b0000, mod_q4});
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_qr_grid_sampler.sv
// Directed bench for qr_grid_sampler: a 1-tap/RL=1 instance on a checkerboard frame and a
// 3-tap/RL=2 version-2 instance on a frame with a noise dot at every module-centre tap.
module tb_qr_grid_sampler;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic          rst_in;

   logic          start1, pix1, busy1, valid1, berr1;
   logic [9:0]    ox1, oy1;
   logic [11:0]   mod1;
   logic [19:0]   addr1;
   logic [440:0]  grid1;

   logic          start3, pix3, busy3, valid3, berr3;
   logic [9:0]    ox3, oy3;
   logic [11:0]   mod3;
   logic [19:0]   addr3;
   logic [624:0]  grid3;

   bit            frame2 [0:307199];
   logic [440:0]  exp1;
   logic [624:0]  exp3;

   int            vectors = 0;
   int            miscompares = 0;
   int            cyc;
   bit            saw_valid, saw_busy;

   qr_grid_sampler dut1 (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_sample  (start1),
      .origin_x      (ox1),
      .origin_y      (oy1),
      .mod_size_q4   (mod1),
      .pixel_data    (pix1),
      .pixel_address (addr1),
      .qr_grid       (grid1),
      .busy          (busy1),
      .grid_valid    (valid1),
      .bounds_error  (berr1)
   );

   qr_grid_sampler #(.VERSION(2), .TAPS(3), .READ_LATENCY(2)) dut3 (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_sample  (start3),
      .origin_x      (ox3),
      .origin_y      (oy3),
      .mod_size_q4   (mod3),
      .pixel_data    (pix3),
      .pixel_address (addr3),
      .qr_grid       (grid3),
      .busy          (busy3),
      .grid_valid    (valid3),
      .bounds_error  (berr3)
   );

   // Checkerboard of 5-px squares; module centres land on 85+5k, so module (r,c) is dark when r+c is odd.
   function automatic logic frame1(input logic [19:0] a);
      int ai, x, y;
      ai = int'(a);
      x  = ai % 640;
      y  = ai / 640;
      return ((x/5 + y/5) % 2) == 1;
   endfunction

   always_comb pix1 = frame1(addr1);

   always_ff @(posedge clk_in) pix3 <= (addr3 < 20'd307200) ? frame2[addr3] : 1'b0;

   task automatic check_output(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input bit use3, input logic [9:0] ox, input logic [9:0] oy,
                                 input logic [11:0] m);
      if (use3) begin
         ox3 = ox; oy3 = oy; mod3 = m; start3 = 1'b1;
      end else begin
         ox1 = ox; oy1 = oy; mod1 = m; start1 = 1'b1;
      end
      @(posedge clk_in); #1;
      start1 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic run_and_wait(input bit use3, input int limit, input int pulse_at, inout int cnt);
      logic [9:0] sx, sy;
      sx = ox1;
      sy = oy1;
      while (cnt < limit && !(use3 ? valid3 : valid1)) begin
         if (cnt == pulse_at) begin
            start1 = 1'b1; ox1 = 10'd5; oy1 = 10'd5;
         end
         @(posedge clk_in); #1;
         cnt++;
         start1 = 1'b0; ox1 = sx; oy1 = sy;
      end
   endtask

   initial begin
      rst_in = 1'b1;
      start1 = 1'b0; ox1 = '0; oy1 = '0; mod1 = '0;
      start3 = 1'b0; ox3 = '0; oy3 = '0; mod3 = '0;

      for (int r = 0; r < 21; r++)
         for (int c = 0; c < 21; c++)
            exp1[r*21 + c] = ((r + c) % 2) == 1;

      // Paint only the tap pixels of the version-2 frame; the centre tap carries the inverted (noise) value.
      for (int r = 0; r < 25; r++) begin
         for (int c = 0; c < 25; c++) begin
            real cx, cy;
            int  px, py;
            bit  clean;
            clean = ((r*7 + c*3) % 5) < 2;
            cx = 200.0 + (c - 3) * 6.5;
            cy = 150.0 + (r - 3) * 6.5;
            py = int'($floor(cy + 0.5));
            for (int t = 0; t < 3; t++) begin
               px = int'($floor(cx + (t - 1) * 1.625 + 0.5));
               frame2[py*640 + px] = (t == 1) ? ~clean : clean;
            end
            exp3[r*25 + c] = clean;
         end
      end

      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b0;

      check_output("reset_addr1",  1024'(addr1),  1024'(0));
      check_output("reset_grid1",  1024'(grid1),  1024'(0));
      check_output("reset_busy1",  1024'(busy1),  1024'(0));
      check_output("reset_valid1", 1024'(valid1), 1024'(0));
      check_output("reset_berr1",  1024'(berr1),  1024'(0));
      check_output("reset_grid3",  1024'(grid3),  1024'(0));

      apply_stimulus(1'b0, 10'd100, 10'd100, 12'h050);
      cyc = 1;
      check_output("v1_busy_c1", 1024'(busy1), 1024'(1));
      repeat (2) begin @(posedge clk_in); #1; cyc++; end
      check_output("v1_first_addr", 1024'(addr1), 1024'(54485));
      run_and_wait(1'b0, 1400, -1, cyc);
      check_output("v1_valid_cycle", 1024'(cyc),   1024'(1325));
      check_output("v1_busy_done",   1024'(busy1), 1024'(0));
      check_output("v1_grid",        1024'(grid1), 1024'(exp1));
      check_output("v1_berr",        1024'(berr1), 1024'(0));
      @(posedge clk_in); #1;
      check_output("v1_valid_pulse", 1024'(valid1), 1024'(0));
      check_output("v1_grid_hold",   1024'(grid1),  1024'(exp1));

      apply_stimulus(1'b1, 10'd200, 10'd150, 12'h068);
      cyc = 1;
      run_and_wait(1'b1, 6400, -1, cyc);
      check_output("v2_valid_cycle", 1024'(cyc),   1024'(6252));
      check_output("v2_grid",        1024'(grid3), 1024'(exp3));
      check_output("v2_berr",        1024'(berr3), 1024'(0));
      @(posedge clk_in); #1;

      apply_stimulus(1'b0, 10'd5, 10'd5, 12'h050);
      cyc = 1;
      run_and_wait(1'b0, 50, -1, cyc);
      check_output("err_valid_cycle", 1024'(cyc),   1024'(3));
      check_output("err_berr",        1024'(berr1), 1024'(1));
      check_output("err_grid",        1024'(grid1), 1024'(0));
      check_output("err_busy",        1024'(busy1), 1024'(0));
      @(posedge clk_in); #1;
      check_output("err_berr_sticky", 1024'(berr1), 1024'(1));

      apply_stimulus(1'b0, 10'd100, 10'd100, 12'h050);
      cyc = 1;
      check_output("restart_berr_clear", 1024'(berr1), 1024'(0));
      run_and_wait(1'b0, 1400, 500, cyc);
      check_output("restart_valid_cycle", 1024'(cyc),   1024'(1325));
      check_output("restart_grid",        1024'(grid1), 1024'(exp1));
      check_output("restart_berr",        1024'(berr1), 1024'(0));
      @(posedge clk_in); #1;

      apply_stimulus(1'b0, 10'd100, 10'd100, 12'h050);
      cyc = 1;
      run_and_wait(1'b0, 700, -1, cyc);
      check_output("abort_no_early_valid", 1024'(valid1), 1024'(0));
      rst_in = 1'b1;
      start1 = 1'b1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      start1 = 1'b0;
      check_output("abort_addr",  1024'(addr1),  1024'(0));
      check_output("abort_grid",  1024'(grid1),  1024'(0));
      check_output("abort_busy",  1024'(busy1),  1024'(0));
      check_output("abort_valid", 1024'(valid1), 1024'(0));
      check_output("abort_berr",  1024'(berr1),  1024'(0));
      saw_valid = 1'b0;
      saw_busy  = 1'b0;
      repeat (1400) begin
         @(posedge clk_in); #1;
         if (valid1) saw_valid = 1'b1;
         if (busy1)  saw_busy  = 1'b1;
      end
      check_output("abort_no_valid", 1024'(saw_valid), 1024'(0));
      check_output("abort_idle",     1024'(saw_busy),  1024'(0));

      apply_stimulus(1'b0, 10'd100, 10'd100, 12'h050);
      cyc = 1;
      run_and_wait(1'b0, 1400, -1, cyc);
      check_output("rerun_valid_cycle", 1024'(cyc),   1024'(1325));
      check_output("rerun_grid",        1024'(grid1), 1024'(exp1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
